// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant and a mux select.
// An optional hold limit preempts an owner that keeps the resource while others wait.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;

  logic [1:0] owner;
  logic [1:0] next_ptr;
  logic [3:0] others;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;

  // First set bit of r, scanning upward from p with wrap-around.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  always_comb begin
    owner     = sel_q;
    next_ptr  = owner + 2'd1;
    others    = req & ~onehot(owner);
    pick_idle = rr_pick(req, ptr_q);
    // The owner sits at lowest priority once the pointer moves past it.
    pick_next = rr_pick(others, next_ptr);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = pick_idle;
          gnt_d   = onehot(pick_idle);
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (!req[owner]) begin
          // Release wins over a coincident hold-limit expiry.
          ptr_d = next_ptr;
          cnt_d = '0;
          if (|others) begin
            sel_d = pick_next;
            gnt_d = onehot(pick_next);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (HOLD_EN && (cnt_q == HOLD_LAST) && (|others)) begin
          ptr_d     = next_ptr;
          sel_d     = pick_next;
          gnt_d     = onehot(pick_next);
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (|others) begin
          if (HOLD_EN && (cnt_q != HOLD_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // A lone owner never accumulates hold time.
          cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == GRANT);
  assign preempt = preempt_q;

endmodule
